// File: rtl/sha256_msg_padder_pkg.sv
// Shared SHA-256 constants: padder state encoding, block-count codes, length limits
// and the padding helper used by the padder (the hash core imports the same package).
package sha256_msg_padder_pkg;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        PAD     = 3'd1,
        ISSUE   = 3'd2,
        WAIT0   = 3'd3,
        WAIT1   = 3'd4,
        DRAIN   = 3'd5
    } pad_state_t;

    localparam logic [1:0] BLK_TYPE_ONE      = 2'd0;
    localparam logic [1:0] BLK_TYPE_TWO      = 2'd2;
    localparam logic [6:0] MAX_MSG_BYTES     = 7'd119;
    localparam logic [6:0] ONE_BLK_MAX_BYTES = 7'd55;

    // 0x80 terminator at byte len, zeros after it, 64-bit bit length at the end of
    // the first block (len <= 55) or of the second block.
    function automatic logic [1023:0] pad_block(input logic [1023:0] data,
                                                input logic [6:0]    len);
        logic [1023:0] r;
        logic [63:0]   bit_len;
        r = data;
        for (int i = 0; i < 128; i++) begin
            if (i == int'(len))
                r[1023 - 8*i -: 8] = 8'h80;
            else if (i > int'(len))
                r[1023 - 8*i -: 8] = 8'h00;
        end
        bit_len = {54'd0, len, 3'b000};
        if (len <= ONE_BLK_MAX_BYTES)
            r[575:512] = bit_len;
        else
            r[63:0] = bit_len;
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Collects a byte-aligned message of up to 119 bytes, pads it into one or two
// 512-bit SHA-256 blocks and hands them to the hash core one block at a time.
//
// state   | meaning
// COLLECT | idle / accepting message words
// PAD     | apply terminator, zero fill and length (one cycle)
// ISSUE   | pulse start with block 0 on msg
// WAIT0   | waiting for the core to finish block 0
// WAIT1   | block 1 on msg, waiting for the core to finish it
// DRAIN   | message too long, discarding words until in_last
module sha256_msg_padder
    import sha256_msg_padder_pkg::*;
#(
    parameter logic [1:0] TWO_BLK_TYPE = BLK_TYPE_TWO,
    parameter logic [1:0] ONE_BLK_TYPE = BLK_TYPE_ONE
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         start,
    output logic [511:0] msg,
    output logic [1:0]   blk_type,
    input  logic         blk_done,
    output logic         busy,
    output logic         error
);

    pad_state_t     state, state_nxt;
    logic [1023:0]  buffer;
    logic [1023:0]  padded;
    logic [4:0]     word_idx;
    logic [6:0]     byte_cnt;
    logic [6:0]     last_bytes;
    logic [6:0]     total;
    logic           two_blk;
    logic           accept;
    logic           err_set;

    assign in_ready   = (state == COLLECT) || (state == DRAIN);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != COLLECT);
    assign start      = (state == ISSUE);
    assign last_bytes = (in_bytes == 2'd0) ? 7'd4 : {5'd0, in_bytes};
    assign total      = byte_cnt + last_bytes;
    assign padded     = pad_block(buffer, byte_cnt);

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (in_last) begin
                        if (total <= MAX_MSG_BYTES)
                            state_nxt = PAD;
                        else
                            err_set = 1'b1;
                    end else if (word_idx == 5'd30) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            PAD:   state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT0;
            WAIT0: if (blk_done) state_nxt = two_blk ? WAIT1 : COLLECT;
            WAIT1: if (blk_done) state_nxt = COLLECT;
            DRAIN: begin
                if (accept && in_last) begin
                    err_set   = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= COLLECT;
            word_idx <= '0;
            byte_cnt <= '0;
            error    <= 1'b0;
            two_blk  <= 1'b0;
            blk_type <= ONE_BLK_TYPE;
            msg      <= '0;
        end else begin
            state <= state_nxt;
            error <= err_set;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        // word w occupies bits 1023-32w down to 992-32w
                        buffer[{~word_idx, 5'h1f} -: 32] <= in_data;
                        if (in_last) begin
                            word_idx <= '0;
                            byte_cnt <= (total <= MAX_MSG_BYTES) ? total : 7'd0;
                        end else begin
                            word_idx <= word_idx + 5'd1;
                            byte_cnt <= byte_cnt + 7'd4;
                        end
                    end
                end
                PAD: begin
                    buffer   <= padded;
                    msg      <= padded[1023:512];
                    two_blk  <= (byte_cnt > ONE_BLK_MAX_BYTES);
                    blk_type <= (byte_cnt > ONE_BLK_MAX_BYTES) ? TWO_BLK_TYPE : ONE_BLK_TYPE;
                    byte_cnt <= '0;
                end
                WAIT0: begin
                    if (blk_done && two_blk)
                        msg <= buffer[511:0];
                end
                DRAIN: begin
                    word_idx <= '0;
                    byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: abc, 80-byte header, 55/56-byte boundary,
// overflow/drain, input gaps and reset while the second block is in flight.
module tb_sha256_msg_padder;

    logic         CLK = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         start;
    logic [511:0] msg;
    logic [1:0]   blk_type;
    logic         blk_done;
    logic         busy;
    logic         error;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int err_cnt = 0;

    logic [511:0] ref0, ref1;

    sha256_msg_padder dut (
        .CLK      (CLK),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_bytes (in_bytes),
        .start    (start),
        .msg      (msg),
        .blk_type (blk_type),
        .blk_done (blk_done),
        .busy     (busy),
        .error    (error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (start) start_cnt++;
        if (error) err_cnt++;
    end

    function automatic logic [7:0] msg_byte(input int k);
        return 8'(k + 1);
    endfunction

    // Reference padded message for the msg_byte pattern of length L
    function automatic logic [1023:0] expect_pad(input int len);
        logic [1023:0] r;
        r = '0;
        for (int k = 0; k < len; k++) r[1023 - 8*k -: 8] = msg_byte(k);
        r[1023 - 8*len -: 8] = 8'h80;
        if (len <= 55) r[575:512] = 64'(len * 8);
        else           r[63:0]    = 64'(len * 8);
        return r;
    endfunction

    task automatic send_word(input logic [31:0] data, input logic last,
                             input logic [1:0] nbytes, output bit ok);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        in_bytes = nbytes;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
                @(posedge CLK); #1;
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input int len, input bit gaps);
        int nw;
        bit ok;
        logic [31:0] w;
        nw = (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
            for (int b = 0; b < 4; b++)
                w[31 - 8*b -: 8] = (4*i + b < len) ? msg_byte(4*i + b) : 8'hEE;
            send_word(w, (i == nw - 1), 2'(len % 4), ok);
            if (!ok) begin
                n_cmp++; n_bad++;
                $display("FAIL handshake: word %0d not accepted within bound", i);
            end
        end
    endtask

    task automatic pulse_done();
        blk_done = 1'b1;
        @(posedge CLK); #1;
        blk_done = 1'b0;
    endtask

    // Send one message (abc word or msg_byte pattern) and walk it through the core handshake
    task automatic run_msg(input int len, input bit gaps, input bit abc,
                           output bit got_start, output logic [511:0] b0,
                           output logic [511:0] b1, output logic [1:0] bt,
                           output logic busy_mid);
        bit ok;
        start_cnt = 0;
        err_cnt   = 0;
        b1 = '0;
        busy_mid = 1'b0;
        if (abc) begin
            send_word(32'h61626300, 1'b1, 2'd3, ok);
            if (!ok) begin
                n_cmp++; n_bad++;
                $display("FAIL handshake: abc word not accepted");
            end
        end else begin
            send_msg(len, gaps);
        end
        got_start = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge CLK);
            if (start) begin got_start = 1'b1; break; end
        end
        b0 = msg;
        bt = blk_type;
        @(posedge CLK); #1;
        busy_mid = busy;
        pulse_done();
        if (!abc && len > 55) begin
            b1 = msg;
            busy_mid = busy_mid & busy;
            repeat (2) begin @(posedge CLK); #1; end
            pulse_done();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_bytes = 2'd0; blk_done = 1'b0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", start); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (blk_type !== 2'd0) begin n_bad++; $display("FAIL reset_blk_type: got %0d want 0", blk_type); end
        n_cmp++; if (msg !== 512'd0) begin n_bad++; $display("FAIL reset_msg: got %h want 0", msg); end
        start_cnt = 0;
        pulse_done();
        repeat (2) begin @(posedge CLK); #1; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_done_busy: got %b want 0", busy); end
        n_cmp++; if (start_cnt !== 0) begin n_bad++; $display("FAIL idle_done_start: got %0d want 0", start_cnt); end
    endtask

    task automatic test_abc();
        bit gs; logic [511:0] b0, b1; logic [1:0] bt; logic bm;
        run_msg(3, 1'b0, 1'b1, gs, b0, b1, bt, bm);
        n_cmp++; if (gs !== 1'b1) begin n_bad++; $display("FAIL abc_start_seen: got %b want 1", gs); end
        n_cmp++; if (b0 !== {32'h61626380, 448'd0, 32'h00000018}) begin n_bad++; $display("FAIL abc_block: got %h", b0); end
        n_cmp++; if (bt !== 2'd0) begin n_bad++; $display("FAIL abc_blk_type: got %0d want 0", bt); end
        n_cmp++; if (bm !== 1'b1) begin n_bad++; $display("FAIL abc_busy_wait: got %b want 1", bm); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abc_busy_after: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abc_ready_after: got %b want 1", in_ready); end
        n_cmp++; if (start_cnt !== 1) begin n_bad++; $display("FAIL abc_start_count: got %0d want 1", start_cnt); end
    endtask

    task automatic test_header80();
        bit gs; logic [511:0] b0, b1; logic [1:0] bt; logic bm;
        logic [1023:0] e;
        e = expect_pad(80);
        run_msg(80, 1'b0, 1'b0, gs, b0, b1, bt, bm);
        ref0 = b0; ref1 = b1;
        n_cmp++; if (b0[511:480] !== 32'h01020304) begin n_bad++; $display("FAIL h80_b0_word0: got %h want 01020304", b0[511:480]); end
        n_cmp++; if (b0[31:0] !== 32'h3d3e3f40) begin n_bad++; $display("FAIL h80_b0_word15: got %h want 3d3e3f40", b0[31:0]); end
        n_cmp++; if (b0 !== e[1023:512]) begin n_bad++; $display("FAIL h80_block0: got %h", b0); end
        n_cmp++; if (b1[511:480] !== 32'h41424344) begin n_bad++; $display("FAIL h80_b1_word0: got %h want 41424344", b1[511:480]); end
        n_cmp++; if (b1[383:376] !== 8'h80) begin n_bad++; $display("FAIL h80_b1_byte16: got %h want 80", b1[383:376]); end
        n_cmp++; if (b1[31:0] !== 32'h00000280) begin n_bad++; $display("FAIL h80_b1_len: got %h want 00000280", b1[31:0]); end
        n_cmp++; if (b1 !== e[511:0]) begin n_bad++; $display("FAIL h80_block1: got %h", b1); end
        n_cmp++; if (bt !== 2'd2) begin n_bad++; $display("FAIL h80_blk_type: got %0d want 2", bt); end
        n_cmp++; if (bm !== 1'b1) begin n_bad++; $display("FAIL h80_busy_wait: got %b want 1", bm); end
        n_cmp++; if (start_cnt !== 1) begin n_bad++; $display("FAIL h80_start_count: got %0d want 1", start_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL h80_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_boundary();
        bit gs; logic [511:0] b0, b1; logic [1:0] bt; logic bm;
        logic [1023:0] e;
        e = expect_pad(55);
        run_msg(55, 1'b0, 1'b0, gs, b0, b1, bt, bm);
        n_cmp++; if (b0[95:64] !== 32'h35363780) begin n_bad++; $display("FAIL b55_word13: got %h want 35363780", b0[95:64]); end
        n_cmp++; if (b0[63:0] !== 64'h1b8) begin n_bad++; $display("FAIL b55_len: got %h want 1b8", b0[63:0]); end
        n_cmp++; if (b0 !== e[1023:512]) begin n_bad++; $display("FAIL b55_block: got %h", b0); end
        n_cmp++; if (bt !== 2'd0) begin n_bad++; $display("FAIL b55_blk_type: got %0d want 0", bt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b55_busy_after: got %b want 0", busy); end
        e = expect_pad(56);
        run_msg(56, 1'b0, 1'b0, gs, b0, b1, bt, bm);
        n_cmp++; if (b0[95:64] !== 32'h35363738) begin n_bad++; $display("FAIL b56_word13: got %h want 35363738", b0[95:64]); end
        n_cmp++; if (b0[63:0] !== 64'h8000000000000000) begin n_bad++; $display("FAIL b56_tail: got %h want 8000000000000000", b0[63:0]); end
        n_cmp++; if (b1[63:0] !== 64'h1c0) begin n_bad++; $display("FAIL b56_len: got %h want 1c0", b1[63:0]); end
        n_cmp++; if (b1 !== e[511:0]) begin n_bad++; $display("FAIL b56_block1: got %h", b1); end
        n_cmp++; if (bt !== 2'd2) begin n_bad++; $display("FAIL b56_blk_type: got %0d want 2", bt); end
        n_cmp++; if (start_cnt !== 1) begin n_bad++; $display("FAIL b56_start_count: got %0d want 1", start_cnt); end
    endtask

    task automatic test_overflow();
        bit gs; logic [511:0] b0, b1; logic [1:0] bt; logic bm;
        start_cnt = 0; err_cnt = 0;
        send_msg(124, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL ovf31_error_count: got %0d want 1", err_cnt); end
        n_cmp++; if (start_cnt !== 0) begin n_bad++; $display("FAIL ovf31_start_count: got %0d want 0", start_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf31_busy: got %b want 0", busy); end
        start_cnt = 0; err_cnt = 0;
        send_msg(132, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL drain_error_count: got %0d want 1", err_cnt); end
        n_cmp++; if (start_cnt !== 0) begin n_bad++; $display("FAIL drain_start_count: got %0d want 0", start_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready_after: got %b want 1", in_ready); end
        run_msg(3, 1'b0, 1'b1, gs, b0, b1, bt, bm);
        n_cmp++; if (b0 !== {32'h61626380, 448'd0, 32'h00000018}) begin n_bad++; $display("FAIL ovf_abc_block: got %h", b0); end
        n_cmp++; if (start_cnt !== 1) begin n_bad++; $display("FAIL ovf_abc_start_count: got %0d want 1", start_cnt); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL ovf_abc_error_count: got %0d want 0", err_cnt); end
    endtask

    task automatic test_gaps();
        bit gs; logic [511:0] b0, b1; logic [1:0] bt; logic bm;
        run_msg(80, 1'b1, 1'b0, gs, b0, b1, bt, bm);
        n_cmp++; if (b0 !== ref0) begin n_bad++; $display("FAIL gaps_block0: got %h", b0); end
        n_cmp++; if (b1 !== ref1) begin n_bad++; $display("FAIL gaps_block1: got %h", b1); end
        n_cmp++; if (bt !== 2'd2) begin n_bad++; $display("FAIL gaps_blk_type: got %0d want 2", bt); end
        n_cmp++; if (start_cnt !== 1) begin n_bad++; $display("FAIL gaps_start_count: got %0d want 1", start_cnt); end
    endtask

    task automatic test_reset_wait1();
        bit gs; logic [511:0] b0, b1; logic [1:0] bt; logic bm;
        start_cnt = 0;
        send_msg(80, 1'b0);
        gs = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge CLK);
            if (start) begin gs = 1'b1; break; end
        end
        n_cmp++; if (gs !== 1'b1) begin n_bad++; $display("FAIL rw1_start_seen: got %b want 1", gs); end
        @(posedge CLK); #1;
        pulse_done();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rw1_busy_in_wait1: got %b want 1", busy); end
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rw1_busy: got %b want 0", busy); end
        n_cmp++; if (msg !== 512'd0) begin n_bad++; $display("FAIL rw1_msg: got %h want 0", msg); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rw1_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (blk_type !== 2'd0) begin n_bad++; $display("FAIL rw1_blk_type: got %0d want 0", blk_type); end
        repeat (4) begin @(posedge CLK); #1; end
        n_cmp++; if (start_cnt !== 1) begin n_bad++; $display("FAIL rw1_no_restart: got %0d want 1", start_cnt); end
        run_msg(3, 1'b0, 1'b1, gs, b0, b1, bt, bm);
        n_cmp++; if (b0 !== {32'h61626380, 448'd0, 32'h00000018}) begin n_bad++; $display("FAIL rw1_abc_block: got %h", b0); end
        n_cmp++; if (start_cnt !== 1) begin n_bad++; $display("FAIL rw1_abc_start_count: got %0d want 1", start_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rw1_abc_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_header80();
        test_boundary();
        test_overflow();
        test_gaps();
        test_reset_wait1();
        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
